// File: rtl/reg_file_sb.sv
// Multi-read-port register file with optional hardwired zero register, same-cycle
// write-to-read bypass and a per-register pending-write counter scoreboard.
module reg_file_sb #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2,
    parameter int CNT_WIDTH     = 2,
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] RA,
    output logic [NUM_READ*WORD_WIDTH-1:0]    RD,
    output logic [NUM_READ-1:0]               RBUSY,
    input  logic [ADDRESS_WIDTH-1:0]          WA3,
    input  logic [WORD_WIDTH-1:0]             WD3,
    input  logic                              WEN,
    input  logic [ADDRESS_WIDTH-1:0]          IA,
    input  logic                              IEN,
    output logic                              IREADY
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [WORD_WIDTH-1:0] r_regs [DEPTH];
    logic [CNT_WIDTH-1:0]  r_cnt  [DEPTH];

    logic w_wa_zero;
    logic w_ia_zero;
    logic w_write;
    logic w_issue;
    logic w_retire;

    assign w_wa_zero = (ZERO_REG != 0) && (WA3 == '0);
    assign w_ia_zero = (ZERO_REG != 0) && (IA == '0);

    // Issue handshake: an issue is accepted on any rising edge where IEN and
    // IREADY are both high; IREADY looks only at the current count, so a retire
    // to the same register in that cycle cannot make room for the issue.
    assign IREADY   = (r_cnt[IA] != CNT_MAX);
    assign w_issue  = IEN && IREADY && !w_ia_zero;
    assign w_write  = WEN && !w_wa_zero;
    assign w_retire = WEN && (r_cnt[WA3] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_regs[j] <= '0;
            end
        end else if (w_write) begin
            r_regs[WA3] <= WD3;
        end
    end

    // An issue and a retire hitting the same register cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (w_issue && (IA == ADDRESS_WIDTH'(j)) && !(w_retire && (WA3 == ADDRESS_WIDTH'(j)))) begin
                    r_cnt[j] <= r_cnt[j] + CNT_ONE;
                end else if (w_retire && (WA3 == ADDRESS_WIDTH'(j)) && !(w_issue && (IA == ADDRESS_WIDTH'(j)))) begin
                    r_cnt[j] <= r_cnt[j] - CNT_ONE;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] w_ra;
        logic [WORD_WIDTH-1:0]    w_rd;
        logic                     w_busy;

        assign w_ra = RA[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        // A bypassed write retires one pending write, so busy needs a second one.
        always_comb begin
            w_rd   = r_regs[w_ra];
            w_busy = (r_cnt[w_ra] != '0);
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd   = '0;
                w_busy = 1'b0;
            end else if ((BYPASS != 0) && WEN && (WA3 == w_ra)) begin
                w_rd   = WD3;
                w_busy = (r_cnt[w_ra] > CNT_ONE);
            end
        end

        assign RD[g*WORD_WIDTH +: WORD_WIDTH] = w_rd;
        assign RBUSY[g]                       = w_busy;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with async reset, hardwired zero register, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined core. Issue logic marks destination registers as pending. Writeback retires them. Decode reads operands and per-operand busy flags to decide stalls.

## Interface
- `WORD_WIDTH`, 32, data width of each register.
- `ADDRESS_WIDTH`, 5, register address width; depth = 2**ADDRESS_WIDTH.
- `NUM_READ`, 2, number of read ports (>=1).
- `CNT_WIDTH`, 2, width of each pending-write counter; max outstanding writes per register = 2**CNT_WIDTH-1.
- `BYPASS`, 1, 1 = write data forwarded to matching read ports in the same cycle.
- `ZERO_REG`, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RA`  in  NUM_READ*ADDRESS_WIDTH  read addresses; port i = `RA[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]`.
- `RD`  out  NUM_READ*WORD_WIDTH  read data; port i = `RD[i*WORD_WIDTH +: WORD_WIDTH]`.
- `RBUSY`  out  NUM_READ  port i operand has outstanding writes not yet visible.
- `WA3`  in  ADDRESS_WIDTH  writeback address.
- `WD3`  in  WORD_WIDTH  writeback data.
- `WEN`  in  1  writeback enable.
- `IA`  in  ADDRESS_WIDTH  issue destination address.
- `IEN`  in  1  issue request.
- `IREADY`  out  1  issue can be accepted this cycle; issue fires on `IEN && IREADY`.

## Operation
- State: register array `regs[2**ADDRESS_WIDTH]`, counter array `cnt[2**ADDRESS_WIDTH]` (CNT_WIDTH bits each).
- Reset (`rst_n`=0, async): all `regs` = 0, all `cnt` = 0. Consequently `RD` = 0, `RBUSY` = 0 and `IREADY` = 1 for every address while in reset.
- Write: on posedge with `WEN`, `regs[WA3]` <= `WD3`. Exception: `WA3`=0 with `ZERO_REG`=1 writes nothing.
- Retire: on posedge with `WEN`, `cnt[WA3]` decrements if nonzero. A write to a register with `cnt`=0 is legal and leaves it at 0.
- Issue: on posedge with `IEN && IREADY`, `cnt[IA]` increments.
  - `IA`=0 with `ZERO_REG`=1 is accepted with no count change.
- `IREADY` = `cnt[IA] != max`. It depends on the current count only; a same-cycle retire to `IA` does not raise it.
- Simultaneous issue and retire on the same register: net `cnt` unchanged.
- Read port i, combinational:
  - If `ZERO_REG` and `RA`=0: `RD`=0, `RBUSY`=0.
  - Else if `BYPASS` and `WEN` and `WA3`==`RA`: `RD`=`WD3`, `RBUSY` = (`cnt[RA]` > 1).
  - Else: `RD`=`regs[RA]`, `RBUSY` = (`cnt[RA]` != 0).
- `BYPASS`=0: `RD` shows old contents and `RBUSY` uses the current `cnt` with no adjustment.
- Counters never wrap. Overflow is prevented by `IREADY`; underflow is prevented by the zero check.

## Timing
- Read latency 0, combinational from `RA`, `WEN`, `WA3`, `WD3`.
- Write and retire take effect at the next rising edge. Without bypass, data is visible 1 cycle after `WEN`.
- Issue takes effect at the rising edge. `RBUSY` for that register rises in the following cycle.
- `rst_n` assertion mid-operation clears state immediately, independent of `clk`. Deassertion is synchronised externally. The first update occurs on the first edge with `rst_n`=1.
- No output is registered. All outputs are valid whenever inputs are stable before the edge.

## Test plan
- Reset: drive writes, then pulse `rst_n`=0 between edges. Required: `RD` for all addresses = 0 immediately, `RBUSY`=0, `IREADY`=1.
- Zero register: `WEN`=1, `WA3`=0, `WD3`=32'hDEADBEEF, and issue `IA`=0. Required next cycle: `RA`=0 gives `RD`=0, `RBUSY`=0.
- Bypass: write `x5`=32'h1111, then `WEN`=1, `WA3`=5, `WD3`=32'h2222 with `RA` port1=5. Required: port1 `RD`=32'h2222 in the same cycle. With `BYPASS`=0 it shows 32'h1111 that cycle and 32'h2222 the next.
- Scoreboard: issue `IA`=7 three times (`CNT_WIDTH`=2). Required:
  - `IREADY`=0 when `IA`=7 on the fourth cycle, and `cnt` stays 3.
  - Three writebacks to 7 follow. `RBUSY` is 1,1,0 during each writeback cycle (bypass), then 0 afterwards.
- Simultaneous events: with `cnt[9]`=1, issue `IA`=9 and write `WA3`=9 in the same cycle. Required: `cnt[9]` stays 1 and `RBUSY` for 9 is 1 the next cycle.
- Stray write: `WEN` to `x12` with `cnt`=0. Required: data is written and `cnt[12]` stays 0 (no underflow; a subsequent issue gives `cnt`=1).
